// File: rtl/mem_access_unit.sv
// Load/store unit: lane alignment, sign/zero extension and LWL/LWR/SWL/SWR merge.
// Define MISALIGN_SPLIT_EN to split lane-crossing accesses into two bus beats.
module mem_access_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_rt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  input  logic                  mem_gnt,
  output logic [31:0]           mem_addr,
  output logic [DATA_W/8-1:0]   mem_strb,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int WB = 2 * NB;
  localparam int WW = 2 * DATA_W;

`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam logic [3:0] OP_LB  = 4'd0,  OP_LH  = 4'd1,  OP_LW  = 4'd2,  OP_LBU = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4,  OP_LWL = 4'd5,  OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8,  OP_SH  = 4'd9,  OP_SW  = 4'd10;
  localparam logic [3:0] OP_SWL = 4'd11, OP_SWR = 4'd12;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ISSUE2, WAIT2, RESP} state_e;

  state_e            state_q;
  logic [3:0]        op_q;
  logic [LB-1:0]     off_q;
  logic [31:0]       rt_q;
  logic              two_q;
  logic [NB-1:0]     hi_strb_q;
  logic [DATA_W-1:0] hi_wdata_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              rsp_valid_q, rsp_err_q, mem_req_q, mem_we_q;
  logic [31:0]       rsp_data_q, mem_addr_q;
  logic [NB-1:0]     mem_strb_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // Accept-time decode: strobes and data laid out over a two-beat lane window.
  logic [LB-1:0] acc_off, acc_wb;
  logic [1:0]    acc_k;
  logic [3:0]    acc_m4;
  logic [31:0]   acc_d4;
  logic          acc_legal, acc_unal, acc_cross, acc_err;
  logic [WB-1:0] acc_strb;
  logic [WW-1:0] acc_wdata;

  always_comb begin
    acc_off   = req_addr[LB-1:0];
    acc_wb    = acc_off & ~LB'(3);
    acc_k     = req_addr[1:0];
    acc_legal = 1'b1;
    acc_unal  = 1'b0;
    acc_m4    = 4'b0001;
    acc_d4    = req_rt;
    case (req_op)
      OP_LB, OP_LBU, OP_SB: acc_m4 = 4'b0001;
      OP_LH, OP_LHU, OP_SH: acc_m4 = 4'b0011;
      OP_LW, OP_SW:         acc_m4 = 4'b1111;
      OP_LWL, OP_LWR: begin
        acc_unal = 1'b1;
        acc_m4   = 4'b1111;
      end
      OP_SWL: begin
        acc_unal = 1'b1;
        acc_m4   = 4'b1111 >> ~acc_k;
        acc_d4   = req_rt >> {~acc_k, 3'b000};
      end
      OP_SWR: begin
        acc_unal = 1'b1;
        acc_m4   = 4'b1111 << acc_k;
        acc_d4   = req_rt << {acc_k, 3'b000};
      end
      default: acc_legal = 1'b0;
    endcase
    if (acc_unal) begin
      acc_strb  = WB'(acc_m4) << acc_wb;
      acc_wdata = WW'(acc_d4) << {acc_wb, 3'b000};
    end else begin
      acc_strb  = WB'(acc_m4) << acc_off;
      acc_wdata = WW'(acc_d4) << {acc_off, 3'b000};
    end
    acc_cross = acc_legal && !acc_unal && (|acc_strb[WB-1:NB]);
    acc_err   = !acc_legal || (acc_cross && !SPLIT_EN);
  end

  // Completion: second beat (if any) sits above the first in the lane window.
  logic [WW-1:0]  dwin;
  logic [LB-1:0]  wb_c;
  logic [1:0]     k_c;
  logic [31:0]    sh, word, lmask, result_d;

  always_comb begin
    dwin     = (state_q == WAIT2) ? {mem_rdata, rdata1_q} : WW'(mem_rdata);
    wb_c     = off_q & ~LB'(3);
    k_c      = off_q[1:0];
    sh       = 32'(dwin >> {off_q, 3'b000});
    word     = 32'(dwin >> {wb_c, 3'b000});
    lmask    = '0;
    result_d = '0;
    case (op_q)
      OP_LB:  result_d = {{24{sh[7]}}, sh[7:0]};
      OP_LBU: result_d = {24'h0, sh[7:0]};
      OP_LH:  result_d = {{16{sh[15]}}, sh[15:0]};
      OP_LHU: result_d = {16'h0, sh[15:0]};
      OP_LW:  result_d = sh;
      OP_LWL: begin
        lmask    = 32'hFFFF_FFFF << {~k_c, 3'b000};
        result_d = (word << {~k_c, 3'b000}) | (rt_q & ~lmask);
      end
      OP_LWR: begin
        lmask    = 32'hFFFF_FFFF >> {k_c, 3'b000};
        result_d = (word >> {k_c, 3'b000}) | (rt_q & ~lmask);
      end
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      off_q       <= '0;
      rt_q        <= '0;
      two_q       <= 1'b0;
      hi_strb_q   <= '0;
      hi_wdata_q  <= '0;
      rdata1_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_strb_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          op_q       <= req_op;
          off_q      <= acc_off;
          rt_q       <= req_rt;
          two_q      <= acc_cross && SPLIT_EN;
          hi_strb_q  <= req_op[3] ? acc_strb[WB-1:NB] : '1;
          hi_wdata_q <= acc_wdata[WW-1:DATA_W];
          if (acc_err) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
          end else begin
            state_q     <= ISSUE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_op[3];
            mem_addr_q  <= {req_addr[31:LB], LB'(0)};
            mem_strb_q  <= req_op[3] ? acc_strb[NB-1:0] : '1;
            mem_wdata_q <= acc_wdata[DATA_W-1:0];
          end
        end
        ISSUE: if (mem_gnt) begin
          mem_req_q <= 1'b0;
          state_q   <= WAIT;
        end
        WAIT: if (mem_rvalid) begin
          if (two_q) begin
            rdata1_q    <= mem_rdata;
            state_q     <= ISSUE2;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= mem_addr_q + 32'(NB);
            mem_strb_q  <= hi_strb_q;
            mem_wdata_q <= hi_wdata_q;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= result_d;
          end
        end
        ISSUE2: if (mem_gnt) begin
          mem_req_q <= 1'b0;
          state_q   <= WAIT2;
        end
        WAIT2: if (mem_rvalid) begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= result_d;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_strb  = mem_strb_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit (DATA_W=32): vector table with beat/response scoreboards,
// plus hand sequences for latency, held response, and mid-transaction reset.
`timescale 1ns/1ps
module tb_mem_access_unit;
  localparam int DW = 32;
  localparam logic [3:0] LB = 0, LH = 1, LW = 2, LBU = 3, LHU = 4, LWL = 5, LWR = 6;
  localparam logic [3:0] SB = 8, SH = 9, SW = 10, SWL = 11, SWR = 12;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0] req_op;
  logic [31:0] req_addr, req_rt, rsp_data, mem_addr;
  logic [DW/8-1:0] mem_strb;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_rt(req_rt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_strb(mem_strb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  typedef struct { logic [31:0] a; logic we; logic [3:0] s; logic [31:0] w; } beat_t;
  typedef struct { logic [31:0] d; logic e; } rsp_t;
  typedef struct {
    logic [3:0] op; logic [31:0] addr, rt, rd0, rd1; int nb;
    beat_t b0, b1; logic [31:0] data; logic err;
  } vec_t;

  beat_t eb_q[$];
  rsp_t exp_q[$];
  logic [31:0] rd_q[$];
  vec_t vt[$];
  int checks = 0, errors = 0;
  int gnt_dly = 0, rv_dly = 0;

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, rt, rd0, rd1,
                              input int nb, input logic [31:0] a0, input logic [3:0] s0,
                              input logic [31:0] w0, input logic [31:0] a1,
                              input logic [3:0] s1, input logic [31:0] w1,
                              input logic [31:0] data, input logic err);
    vec_t v;
    v.op = op; v.addr = addr; v.rt = rt; v.rd0 = rd0; v.rd1 = rd1; v.nb = nb;
    v.b0.a = a0; v.b0.we = op[3]; v.b0.s = s0; v.b0.w = w0;
    v.b1.a = a1; v.b1.we = op[3]; v.b1.s = s1; v.b1.w = w1;
    v.data = data; v.err = err;
    return v;
  endfunction

  // Bus responder: grant after gnt_dly cycles, complete rv_dly cycles after grant.
  int gcnt = 0, rcnt = 0;
  bit rpend = 0, dchk = 0;
  beat_t eb;
  logic [31:0] wmask;
  always @(negedge clk) begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (!rst) begin
      gcnt = 0; rpend = 0; dchk = 0;
    end else begin
      if (dchk) begin
        checks++;
        if (mem_req !== 1'b0) begin
          errors++;
          $display("FAIL mem_req_drop: got %b want 0", mem_req);
        end
        dchk = 0;
      end
      if (rpend) begin
        if (rcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
          rpend = 0;
        end else rcnt--;
      end else if (mem_req) begin
        if (gcnt >= gnt_dly) begin
          mem_gnt = 1'b1; gcnt = 0; rpend = 1; rcnt = rv_dly; dchk = 1;
          checks++;
          if (eb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got addr %h we %b strb %b, want none",
                     mem_addr, mem_we, mem_strb);
          end else begin
            eb = eb_q.pop_front();
            wmask = {{8{eb.s[3]}}, {8{eb.s[2]}}, {8{eb.s[1]}}, {8{eb.s[0]}}};
            if (mem_addr !== eb.a || mem_we !== eb.we || mem_strb !== eb.s ||
                (eb.we && ((mem_wdata & wmask) !== (eb.w & wmask)))) begin
              errors++;
              $display("FAIL beat: got addr %h we %b strb %b wdata %h, want addr %h we %b strb %b wdata %h",
                       mem_addr, mem_we, mem_strb, mem_wdata, eb.a, eb.we, eb.s, eb.w);
            end
          end
        end else gcnt++;
      end
    end
  end

  // Response scoreboard.
  rsp_t er;
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got data %h err %b, want none", rsp_data, rsp_err);
      end else begin
        er = exp_q.pop_front();
        if (rsp_data !== er.d || rsp_err !== er.e) begin
          errors++;
          $display("FAIL rsp: got data %h err %b, want data %h err %b", rsp_data, rsp_err, er.d, er.e);
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt);
    int n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got 0 want 1");
    end
    req_valid = 1'b1; req_op = op; req_addr = a; req_rt = rt;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || eb_q.size() != 0) && n < 200) begin @(posedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL txn_timeout: got %0d rsp/%0d beats pending, want 0", exp_q.size(), eb_q.size());
      exp_q.delete(); eb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    rsp_t r;
    if (v.nb >= 1) begin rd_q.push_back(v.rd0); eb_q.push_back(v.b0); end
    if (v.nb == 2) begin rd_q.push_back(v.rd1); eb_q.push_back(v.b1); end
    r.d = v.data; r.e = v.err;
    exp_q.push_back(r);
    send(v.op, v.addr, v.rt);
    wait_done();
  endtask

  task automatic chk_reset(input string nm);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_req, mem_we} !== 5'b10000 ||
        rsp_data !== 32'h0 || mem_strb !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL %s: got rdy %b rv %b err %b req %b we %b data %h strb %b addr %h wd %h, want 1 0 0 0 0 0 0 0 0",
               nm, req_ready, rsp_valid, rsp_err, mem_req, mem_we, rsp_data, mem_strb, mem_addr, mem_wdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rsp_t r;
    req_valid = 0; req_op = 0; req_addr = 0; req_rt = 0; rsp_ready = 1;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    #1 rst = 1'b0;
    #11 chk_reset("reset_state");
    @(posedge clk); #3 rst = 1'b1;

    vt.push_back(mk(LB,  32'h103, 0, 32'h80FF_0000, 0, 1, 32'h100, 4'hF, 0, 0, 0, 0, 32'hFFFF_FF80, 0));
    vt.push_back(mk(LBU, 32'h103, 0, 32'h80FF_0000, 0, 1, 32'h100, 4'hF, 0, 0, 0, 0, 32'h0000_0080, 0));
    vt.push_back(mk(LH,  32'h102, 0, 32'h80FF_0000, 0, 1, 32'h100, 4'hF, 0, 0, 0, 0, 32'hFFFF_80FF, 0));
    vt.push_back(mk(LHU, 32'h101, 0, 32'h1234_5678, 0, 1, 32'h100, 4'hF, 0, 0, 0, 0, 32'h0000_3456, 0));
    vt.push_back(mk(LH,  32'h101, 0, 32'h0080_0100, 0, 1, 32'h100, 4'hF, 0, 0, 0, 0, 32'hFFFF_8001, 0));
    vt.push_back(mk(LW,  32'h400, 0, 32'hCAFE_BABE, 0, 1, 32'h400, 4'hF, 0, 0, 0, 0, 32'hCAFE_BABE, 0));
    vt.push_back(mk(LWL, 32'h201, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 32'h200, 4'hF, 0, 0, 0, 0, 32'hCCDD_3344, 0));
    vt.push_back(mk(LWR, 32'h201, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 32'h200, 4'hF, 0, 0, 0, 0, 32'h11AA_BBCC, 0));
    vt.push_back(mk(LWL, 32'h203, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 32'h200, 4'hF, 0, 0, 0, 0, 32'hAABB_CCDD, 0));
    vt.push_back(mk(LWR, 32'h203, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 32'h200, 4'hF, 0, 0, 0, 0, 32'h1122_33AA, 0));
    vt.push_back(mk(LWL, 32'h200, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 32'h200, 4'hF, 0, 0, 0, 0, 32'hDD22_3344, 0));
    vt.push_back(mk(SB,  32'h102, 32'h1234_56A5, 0, 0, 1, 32'h100, 4'b0100, 32'h00A5_0000, 0, 0, 0, 0, 0));
    vt.push_back(mk(SH,  32'h102, 32'h0000_BEEF, 0, 0, 1, 32'h100, 4'b1100, 32'hBEEF_0000, 0, 0, 0, 0, 0));
    vt.push_back(mk(SH,  32'h101, 32'hCAFE_1234, 0, 0, 1, 32'h100, 4'b0110, 32'h0012_3400, 0, 0, 0, 0, 0));
    vt.push_back(mk(SW,  32'h300, 32'h1234_5678, 0, 0, 1, 32'h300, 4'hF, 32'h1234_5678, 0, 0, 0, 0, 0));
    vt.push_back(mk(SWL, 32'h301, 32'h1122_3344, 0, 0, 1, 32'h300, 4'b0011, 32'h0000_1122, 0, 0, 0, 0, 0));
    vt.push_back(mk(SWR, 32'h301, 32'h1122_3344, 0, 0, 1, 32'h300, 4'b1110, 32'h2233_4400, 0, 0, 0, 0, 0));
    vt.push_back(mk(SWL, 32'h303, 32'h1122_3344, 0, 0, 1, 32'h300, 4'hF, 32'h1122_3344, 0, 0, 0, 0, 0));
    vt.push_back(mk(SWR, 32'h303, 32'h1122_3344, 0, 0, 1, 32'h300, 4'b1000, 32'h4400_0000, 0, 0, 0, 0, 0));
    vt.push_back(mk(4'd7,  32'h500, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(4'd13, 32'h500, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(4'd15, 32'h500, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`ifdef MISALIGN_SPLIT_EN
    vt.push_back(mk(LH, 32'h103, 0, 32'hAB00_0000, 32'h0000_00CD, 2, 32'h100, 4'hF, 0, 32'h104, 4'hF, 0, 32'hFFFF_CDAB, 0));
    vt.push_back(mk(SW, 32'h302, 32'h1234_5678, 0, 0, 2, 32'h300, 4'b1100, 32'h5678_0000, 32'h304, 4'b0011, 32'h0000_1234, 0, 0));
    vt.push_back(mk(LW, 32'h301, 0, 32'h1122_3344, 32'h5566_7788, 2, 32'h300, 4'hF, 0, 32'h304, 4'hF, 0, 32'h8811_2233, 0));
`else
    vt.push_back(mk(LH, 32'h103, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(SW, 32'h302, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(LW, 32'h301, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`endif

    for (int i = 0; i < vt.size(); i++) begin
      gnt_dly = i % 3;
      rv_dly = (i / 3) % 2;
      run_vec(vt[i]);
    end

    // Minimum latency: accept in cycle N, rsp_valid in N+3.
    gnt_dly = 0; rv_dly = 0;
    rd_q.push_back(32'h0BAD_F00D);
    eb.a = 32'h600; eb.we = 0; eb.s = 4'hF; eb.w = 0;
    eb_q.push_back(eb);
    r.d = 32'h0BAD_F00D; r.e = 0;
    exp_q.push_back(r);
    send(LW, 32'h600, 0);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL latency: got %0d want 3", lat); end
    wait_done();

`ifndef MISALIGN_SPLIT_EN
    // Crossing store without split: error within 2 cycles, no beat.
    r.d = 0; r.e = 1;
    exp_q.push_back(r);
    send(SW, 32'h302, 32'h1234_5678);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    checks++;
    if (lat > 2) begin errors++; $display("FAIL cross_err_latency: got %0d want <=2", lat); end
    wait_done();
`endif

    // Illegal op with response held off for 5 cycles.
    rsp_ready = 0;
    r.d = 0; r.e = 1;
    exp_q.push_back(r);
    send(4'd7, 32'h700, 32'hFFFF_FFFF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_err !== 1'b1 || mem_req !== 1'b0 ||
          rsp_data !== 32'h0) begin
        errors++;
        $display("FAIL held_rsp: got rv %b rdy %b err %b req %b data %h, want 1 0 1 0 0",
                 rsp_valid, req_ready, rsp_err, mem_req, rsp_data);
      end
    end
    @(posedge clk); #1 rsp_ready = 1;
    wait_done();

    // Reset while waiting on a read beat: abort with no response.
    gnt_dly = 0; rv_dly = 6;
    rd_q.push_back(32'h1111_2222);
    eb.a = 32'h800; eb.we = 0; eb.s = 4'hF; eb.w = 0;
    eb_q.push_back(eb);
    send(LW, 32'h800, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL in_wait: got req %b rdy %b rv %b, want 0 0 0", mem_req, req_ready, rsp_valid);
    end
    #2 rst = 1'b0;
    #1 chk_reset("reset_mid_wait");
    rd_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    rv_dly = 0;
    @(posedge clk); #1;
    run_vec(mk(LW, 32'h804, 0, 32'h5555_AAAA, 0, 1, 32'h804, 4'hF, 0, 0, 0, 0, 32'h5555_AAAA, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, bus data width; legal values 32 and 64; NB = DATA_W/8 byte lanes, LB = log2(NB).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  core request valid.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_op  input  4  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW, 11 SWL, 12 SWR; other codes illegal.
REQ-007 req_addr  input  32  byte effective address.
REQ-008 req_rt  input  32  store data, or old rt value merged by LWL/LWR.
REQ-009 rsp_valid  output  1  response valid.
REQ-010 rsp_ready  input  1  core accepts response.
REQ-011 rsp_data  output  32  extended/merged load result; 0 for stores.
REQ-012 rsp_err  output  1  address/opcode error, no bus write performed.
REQ-013 mem_req, mem_we  output  1 each  bus request, write enable.
REQ-014 mem_gnt  input  1  bus accepts request this cycle.
REQ-015 mem_addr  output  32  beat address, low LB bits zero.
REQ-016 mem_strb  output  NB  byte-lane write strobes; all-ones for reads.
REQ-017 mem_wdata  output  DATA_W  lane-aligned store data.
REQ-018 mem_rvalid, mem_rdata  input  1, DATA_W  beat completion (reads and writes) and read data.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, ISSUE2, WAIT2, RESP; req_ready=1 only in IDLE.
REQ-020 IDLE: on req_valid&&req_ready, register op/addr/rt; illegal op -> RESP with rsp_err=1, no bus beat; else -> ISSUE.
REQ-021 ISSUE/ISSUE2: mem_req=1 with stable addr/we/strb/wdata until mem_gnt; then -> WAIT/WAIT2.
REQ-022 WAIT/WAIT2: on mem_rvalid capture mem_rdata; -> ISSUE2 if a second beat is pending, else RESP.
REQ-023 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_ready; then -> IDLE; no new request accepted in the same cycle.
REQ-024 Minimum latency, single beat, gnt and rvalid immediate: accept cycle N, rsp_valid asserted cycle N+3.
REQ-025 Little-endian lanes: byte b of access maps to lane (addr+b) mod NB; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-026 LWL/LWR/SWL/SWR operate on the aligned 32-bit word (addr[1:0] selects bytes; for DATA_W=64 addr[2] selects word half); never split, never err.
REQ-027 LWL keeps rt bytes below the loaded bytes; LWR keeps rt bytes above; SWL/SWR strobe only the written bytes.
REQ-028 An LH/LHU/SH/LW/SW access is "crossing" when (addr mod NB)+size > NB; for DATA_W=64 an LW at addr[2:0]=1..3 is not crossing and completes in one beat.
REQ-029 Non-crossing but misaligned LH/LW (e.g. DATA_W=32, LH at addr[1:0]=1) completes in one beat using lanes addr..addr+size-1.
REQ-030 mem_req deasserts in the cycle after mem_gnt; mem_rvalid outside WAIT/WAIT2 is ignored.

Reset
REQ-031 rst low: state IDLE immediately; req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, mem_req=0, mem_we=0, mem_strb=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset mid-transaction aborts without a response; a pending bus beat is dropped.

Configuration
REQ-033 Macro MISALIGN_SPLIT_EN defined: crossing access issues beat 1 at floor(addr/NB)*NB and beat 2 at +NB, strobes/data split per lane, result assembled after WAIT2, rsp_err=0.
REQ-034 MISALIGN_SPLIT_EN undefined: crossing access -> RESP with rsp_err=1, rsp_data=0, no bus beat; ISSUE2/WAIT2 unreachable.

Verification
REQ-035 DATA_W=32, LB addr 0x103, mem_rdata 0x80FF_0000 -> one read beat at 0x100, rsp_data 0xFFFF_FF80, rsp_err 0.
REQ-036 DATA_W=32, LWL addr 0x201, req_rt 0x1122_3344, mem_rdata 0xAABB_CCDD -> rsp_data 0xCCDD_3344.
REQ-037 DATA_W=32, SW addr 0x302, req_rt 0x1234_5678, split enabled -> beat 1 0x300 strb 1100 wdata 0x5678_0000; beat 2 0x304 strb 0011 wdata 0x0000_1234.
REQ-038 Same SW with MISALIGN_SPLIT_EN undefined -> no mem_req, rsp_err 1 within 2 cycles of accept.
REQ-039 req_op 7 -> rsp_err 1, no mem_req; rsp_ready held low 5 cycles -> rsp_valid stays 1, req_ready stays 0.
REQ-040 rst low during WAIT of LW -> outputs at reset values same cycle; after release, next LW completes normally.
